hpm_ctrl: RTL and testbench

HPM_CTRL -- requirements
Module: hpm_ctrl

---
 rtl/hpm_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_hpm_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/hpm_ctrl.sv
// Hardware performance-monitor controller: CSR block owning the event-mux selects,
// per-counter enable/inhibit, sticky overflow flags and a sequenced clear-all.

module hpm_ctr_lane #(
    parameter int CNT_W = 64
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    input  logic             wr_i,
    input  logic [CNT_W-1:0] wdata_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             ovf_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // A software write beats a coinciding event; the increment is dropped.
    always_comb begin
        cnt_d = cnt_q;
        ovf_o = 1'b0;
        if (clr_i) begin
            cnt_d = '0;
        end else if (wr_i) begin
            cnt_d = wdata_i;
        end else if (inc_i) begin
            cnt_d = cnt_q + CNT_W'(1);
            ovf_o = &cnt_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
endmodule

module hpm_ctrl #(
    parameter int NUM_CNT = 4,
    parameter int CNT_W   = 64
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    output logic [NUM_CNT-1:0][3:0] evu_sel_o,
    input  logic [NUM_CNT-1:0]      evu_event_i,
    input  logic                    csr_req_i,
    output logic                    csr_ready_o,
    input  logic                    csr_we_i,
    input  logic [3:0]              csr_addr_i,
    input  logic [CNT_W-1:0]        csr_wdata_i,
    output logic                    csr_ack_o,
    output logic [CNT_W-1:0]        csr_rdata_o,
    output logic                    csr_err_o,
    output logic                    irq_o
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RESP  = 2'd1;
    localparam logic [1:0] ST_CLEAR = 2'd2;
    localparam int IW = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1;

    logic [1:0]                    state_q, state_d;
    logic                          clr_pend_q, clr_pend_d;
    logic [IW-1:0]                 clr_idx_q, clr_idx_d;
    logic                          en_q, en_d;
    logic [NUM_CNT-1:0]            inh_q, inh_d;
    logic [NUM_CNT-1:0]            ovf_q, ovf_d;
    logic [NUM_CNT-1:0][3:0]       sel_q, sel_d;
    logic [CNT_W-1:0]              rdata_q, rdata_d;
    logic                          err_q, err_d;

    logic [NUM_CNT-1:0][CNT_W-1:0] cnt;
    logic [NUM_CNT-1:0]            inc, cnt_wr, cnt_clr, ovf_set;
    logic [NUM_CNT-1:0]            hit_sel, hit_cnt;
    logic                          hit_ctrl, hit_ovf, mapped;
    logic                          accept, wr, in_clear, last_clr;
    logic [CNT_W-1:0]              rd_val;

    assign accept   = csr_req_i && (state_q == ST_IDLE);
    assign wr       = accept && csr_we_i;
    assign in_clear = (state_q == ST_CLEAR);
    assign last_clr = in_clear && (clr_idx_q == IW'(NUM_CNT - 1));

    always_comb begin
        hit_ctrl = (csr_addr_i == 4'h0);
        hit_ovf  = (csr_addr_i == 4'h1);
        for (int i = 0; i < NUM_CNT; i++) begin
            hit_sel[i] = (csr_addr_i == 4'(2 + i));
            hit_cnt[i] = (csr_addr_i == 4'(8 + i));
        end
        mapped = hit_ctrl | hit_ovf | (|hit_sel) | (|hit_cnt);
    end

    // Read mux; CLR is write-only and always reads back 0.
    always_comb begin
        rd_val = '0;
        if (hit_ctrl) begin
            rd_val[0]            = en_q;
            rd_val[8 +: NUM_CNT] = inh_q;
        end
        if (hit_ovf) rd_val[NUM_CNT-1:0] = ovf_q;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (hit_sel[i]) rd_val[3:0] = sel_q[i];
            if (hit_cnt[i]) rd_val      = cnt[i];
        end
    end

    always_comb begin
        en_d  = en_q;
        inh_d = inh_q;
        sel_d = sel_q;
        if (wr && hit_ctrl) begin
            en_d  = csr_wdata_i[0];
            inh_d = csr_wdata_i[8 +: NUM_CNT];
        end
        for (int i = 0; i < NUM_CNT; i++) begin
            if (wr && hit_sel[i]) sel_d[i] = csr_wdata_i[3:0];
        end
    end

    // W1C clear is applied before the new overflow so a coinciding set wins.
    always_comb begin
        ovf_d = ovf_q;
        if (wr && hit_ovf) ovf_d = ovf_d & ~csr_wdata_i[NUM_CNT-1:0];
        ovf_d = ovf_d | ovf_set;
        if (last_clr) ovf_d = '0;
    end

    always_comb begin
        state_d    = state_q;
        clr_pend_d = clr_pend_q;
        clr_idx_d  = clr_idx_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        case (state_q)
            ST_IDLE: begin
                if (csr_req_i) begin
                    state_d    = ST_RESP;
                    rdata_d    = rd_val;
                    err_d      = !mapped;
                    clr_pend_d = wr && hit_ctrl && csr_wdata_i[1];
                end
            end
            ST_RESP: begin
                clr_idx_d = '0;
                state_d   = clr_pend_q ? ST_CLEAR : ST_IDLE;
            end
            ST_CLEAR: begin
                clr_idx_d = clr_idx_q + IW'(1);
                if (last_clr) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Selects 0000/0001 carry no event; counting is frozen during clear-all.
    for (genvar g = 0; g < NUM_CNT; g++) begin : g_lane
        assign inc[g]     = en_q && !inh_q[g] && (sel_q[g] > 4'd1) && evu_event_i[g] && !in_clear;
        assign cnt_wr[g]  = wr && hit_cnt[g];
        assign cnt_clr[g] = in_clear && (clr_idx_q == IW'(g));

        hpm_ctr_lane #(.CNT_W(CNT_W)) u_lane (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .inc_i   (inc[g]),
            .wr_i    (cnt_wr[g]),
            .wdata_i (csr_wdata_i),
            .clr_i   (cnt_clr[g]),
            .cnt_o   (cnt[g]),
            .ovf_o   (ovf_set[g])
        );
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            clr_pend_q <= 1'b0;
            clr_idx_q  <= '0;
            en_q       <= 1'b0;
            inh_q      <= '0;
            ovf_q      <= '0;
            sel_q      <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_pend_q <= clr_pend_d;
            clr_idx_q  <= clr_idx_d;
            en_q       <= en_d;
            inh_q      <= inh_d;
            ovf_q      <= ovf_d;
            sel_q      <= sel_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    // Outputs are gated by reset so nothing leaks while rst_ni is low.
    assign csr_ready_o = rst_ni && (state_q == ST_IDLE);
    assign csr_ack_o   = rst_ni && (state_q == ST_RESP);
    assign csr_rdata_o = csr_ack_o ? rdata_q : '0;
    assign csr_err_o   = csr_ack_o && err_q;
    assign irq_o       = rst_ni && (|ovf_q);
    assign evu_sel_o   = sel_q;
endmodule

// File: tb/tb_hpm_ctrl.sv
// Scoreboard bench for hpm_ctrl: the driver queues expected responses, a negedge
// monitor checks every ack against the queue head, including 1-cycle latency.

module tb_hpm_ctrl;
    localparam int NC = 4;
    localparam int W  = 64;
    localparam logic [W-1:0] ONES = '1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NC-1:0][3:0] evu_sel;
    logic [NC-1:0]     evu_event = '0;
    logic              req = 1'b0, we = 1'b0;
    logic [3:0]        addr = '0;
    logic [W-1:0]      wdata = '0;
    logic              ready, ack, err, irq;
    logic [W-1:0]      rdata;

    typedef struct {
        logic [W-1:0] rd;
        logic         chk_rd;
        logic         err;
        int           cyc;
    } exp_t;
    exp_t sb[$];

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    hpm_ctrl #(.NUM_CNT(NC), .CNT_W(W)) dut (
        .clk_i(clk), .rst_ni(rst_n), .evu_sel_o(evu_sel), .evu_event_i(evu_event),
        .csr_req_i(req), .csr_ready_o(ready), .csr_we_i(we), .csr_addr_i(addr),
        .csr_wdata_i(wdata), .csr_ack_o(ack), .csr_rdata_o(rdata), .csr_err_o(err),
        .irq_o(irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (ack) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_ack: got ack=1 expected no ack (t=%0t)", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.chk_rd) chk("rdata", rdata, e.rd);
                chk("err", W'(err), W'(e.err));
                chk("ack_latency", W'(cyc), W'(e.cyc + 1));
            end
        end
    end

    // Called at a negedge; issues one access and returns at the negedge after acceptance.
    task automatic acc(input logic w, input logic [3:0] a, input logic [W-1:0] d,
                       input logic [W-1:0] exp_rd, input logic chk_rd, input logic exp_err);
        int n = 0;
        exp_t e;
        while (!ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            chk("ready_timeout", W'(ready), W'(1));
            return;
        end
        req = 1'b1; we = w; addr = a; wdata = d;
        e.rd = exp_rd; e.chk_rd = chk_rd; e.err = exp_err; e.cyc = cyc;
        sb.push_back(e);
        @(negedge clk);
        req = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [W-1:0] d);
        acc(1'b1, a, d, '0, 1'b0, 1'b0);
    endtask

    task automatic rd(input logic [3:0] a, input logic [W-1:0] exp);
        acc(1'b0, a, '0, exp, 1'b1, 1'b0);
    endtask

    task automatic ev(input logic [NC-1:0] m, input int n);
        evu_event = m;
        repeat (n) @(negedge clk);
        evu_event = '0;
    endtask

    initial begin
        int n;
        // reset values
        repeat (3) begin
            @(negedge clk);
            chk("rst_ack", W'(ack), 0);
            chk("rst_rdata", rdata, 0);
            chk("rst_irq", W'(irq), 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", W'(ready), 1);
        rd(4'h0, 0); rd(4'h1, 0); rd(4'h2, 0); rd(4'h8, 0);

        // basic counting
        wr(4'h2, 64'hF2);
        wr(4'h0, 64'h1);
        ev(4'b0001, 5);
        rd(4'h8, 5);
        rd(4'h2, 2);

        // overflow and W1C
        wr(4'h9, ONES);
        wr(4'h3, 64'h3);
        ev(4'b0010, 1);
        chk("irq_ovf", W'(irq), 1);
        rd(4'h9, 0);
        rd(4'h1, 64'h2);
        wr(4'h1, 64'h2);
        chk("irq_w1c", W'(irq), 0);
        rd(4'h1, 0);

        // gating: inhibit, no-event select, global disable
        wr(4'h0, 64'h401);
        rd(4'h0, 64'h401);
        wr(4'h4, 64'h2);
        ev(4'b0100, 10);
        rd(4'hA, 0);
        wr(4'h0, 64'h1);
        wr(4'h4, 64'h1);
        ev(4'b0100, 10);
        rd(4'hA, 0);
        wr(4'h0, 64'h0);
        wr(4'h4, 64'h2);
        ev(4'b1111, 10);
        rd(4'h8, 5); rd(4'h9, 0); rd(4'hA, 0); rd(4'hB, 0);

        // collisions and unmapped addresses
        wr(4'h0, 64'h1);
        @(negedge clk);
        evu_event = 4'b0001;
        wr(4'h8, 64'd100);
        evu_event = '0;
        rd(4'h8, 100);
        acc(1'b0, 4'h7, '0, 0, 1'b1, 1'b1);
        acc(1'b1, 4'hC, 64'h5, 0, 1'b1, 1'b1);
        acc(1'b0, 4'h6, '0, 0, 1'b1, 1'b1);
        @(negedge clk);
        evu_event = 4'b0001;
        wr(4'h2, 64'h0);
        @(negedge clk);
        evu_event = '0;
        rd(4'h8, 101);
        rd(4'h2, 0);

        // clear-all
        wr(4'h3, 64'h3);
        ev(4'b0010, 3);
        wr(4'hB, ONES);
        wr(4'h5, 64'h2);
        ev(4'b1000, 1);
        chk("irq_ovf3", W'(irq), 1);
        rd(4'h9, 3);
        wr(4'h0, 64'h3);
        evu_event = 4'b1111;
        n = 0;
        @(negedge clk);
        while (!ready && n < 20) begin
            n++;
            @(negedge clk);
        end
        evu_event = '0;
        chk("clear_busy_cycles", W'(n), W'(NC));
        rd(4'h8, 0); rd(4'h9, 0); rd(4'hA, 0); rd(4'hB, 0);
        rd(4'h1, 0);
        chk("irq_after_clear", W'(irq), 0);
        rd(4'h0, 64'h1);

        // reset in the second clear cycle
        ev(4'b0010, 2);
        rd(4'h9, 2);
        wr(4'h0, 64'h3);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("rst_clr_ack", W'(ack), 0);
            chk("rst_clr_irq", W'(irq), 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst_clr", W'(ready), 1);
        rd(4'h0, 0); rd(4'h3, 0); rd(4'h9, 0); rd(4'h1, 0);
        repeat (2) @(negedge clk);
        chk("sb_empty", W'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
